// File: rtl/cmp_window_stats_if.sv
// Stream interface for cmp_window_stats: an operand pair with the external
// comparator's flags on the input side, and a per-window result record on the
// output side. Both sides use a valid/ready handshake.
interface cmp_window_stats_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    // Sample side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             aeqb;
    logic             agtb;
    logic             altb;

    // Record side
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] min_val;
    logic             flag_err;

    // Producer of samples and consumer of records
    modport master (
        output in_valid, a, b, aeqb, agtb, altb, out_ready,
        input  in_ready, out_valid, eq_cnt, gt_cnt, lt_cnt,
               max_val, min_val, flag_err
    );

    // The statistics block itself
    modport slave (
        input  in_valid, a, b, aeqb, agtb, altb, out_ready,
        output in_ready, out_valid, eq_cnt, gt_cnt, lt_cnt,
               max_val, min_val, flag_err
    );
endinterface

// File: rtl/cmp_window_stats.sv
// Window statistics for a 4-bit magnitude comparator stream.
// Counts eq/gt/lt outcomes over WINDOW accepted samples, tracks the unsigned
// max/min of every operand seen, and flags any sample whose comparator flags
// disagree with a local compare. A record is offered at the end of each window
// and held until the consumer takes it.
module cmp_window_stats #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    cmp_window_stats_if.slave  bus
);
    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Index of the final sample in a window (counter value before its accept)
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] eq_reg, eq_next;
    logic [CNT_W-1:0] gt_reg, gt_next;
    logic [CNT_W-1:0] lt_reg, lt_next;
    logic [WIDTH-1:0] max_reg, max_next;
    logic [WIDTH-1:0] min_reg, min_next;
    logic             err_reg, err_next;

    logic [2:0]       truth;
    logic [2:0]       flags;
    logic             flags_ok;
    logic [WIDTH-1:0] hi_ab;
    logic [WIDTH-1:0] lo_ab;

    // Local reference compare and the larger/smaller operand of this pair
    always_comb begin
        truth    = {bus.a == bus.b, bus.a > bus.b, bus.a < bus.b};
        flags    = {bus.aeqb, bus.agtb, bus.altb};
        flags_ok = (flags == truth);
        hi_ab    = (bus.a > bus.b) ? bus.a : bus.b;
        lo_ab    = (bus.a < bus.b) ? bus.a : bus.b;
    end

    // Next-state: clear beats everything, then accumulate in ACC or drain in HOLD
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        eq_next    = eq_reg;
        gt_next    = gt_reg;
        lt_next    = lt_reg;
        max_next   = max_reg;
        min_next   = min_reg;
        err_next   = err_reg;

        if (clear || (state_reg == HOLD && bus.out_ready)) begin
            // Abort or completed transfer: start an empty window
            state_next = ACC;
            count_next = '0;
            eq_next    = '0;
            gt_next    = '0;
            lt_next    = '0;
            max_next   = '0;
            min_next   = ALL_ONES;
            err_next   = 1'b0;
        end else if (state_reg == ACC && bus.in_valid) begin
            // A bad flag triple is not counted but still consumes a window slot
            if (flags_ok) begin
                if (truth[2]) begin
                    eq_next = eq_reg + ONE;
                end else if (truth[1]) begin
                    gt_next = gt_reg + ONE;
                end else begin
                    lt_next = lt_reg + ONE;
                end
            end else begin
                err_next = 1'b1;
            end
            max_next   = (hi_ab > max_reg) ? hi_ab : max_reg;
            min_next   = (lo_ab < min_reg) ? lo_ab : min_reg;
            count_next = count_reg + ONE;
            if (count_reg == LAST_IDX) begin
                state_next = HOLD;
            end
        end
    end

    // State and statistics registers, asynchronously reset to an empty window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACC;
            count_reg <= '0;
            eq_reg    <= '0;
            gt_reg    <= '0;
            lt_reg    <= '0;
            max_reg   <= '0;
            min_reg   <= ALL_ONES;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            eq_reg    <= eq_next;
            gt_reg    <= gt_next;
            lt_reg    <= lt_next;
            max_reg   <= max_next;
            min_reg   <= min_next;
            err_reg   <= err_next;
        end
    end

    // Handshakes decode straight from state so reset takes effect without a clock
    always_comb begin
        bus.in_ready  = (state_reg == ACC);
        bus.out_valid = (state_reg == HOLD);
        bus.eq_cnt    = eq_reg;
        bus.gt_cnt    = gt_reg;
        bus.lt_cnt    = lt_reg;
        bus.max_val   = max_reg;
        bus.min_val   = min_reg;
        bus.flag_err  = err_reg;
    end
endmodule

// File: tb/tb_cmp_window_stats.sv
// Bench for cmp_window_stats: a WINDOW=4 instance for directed cases and a
// WINDOW=8 instance for randomized traffic, both checked against a window model
// that recomputes each record from the list of samples accepted in that window.
module tb_cmp_window_stats;
    logic clk = 1'b0;
    logic rst_n;
    logic clear4;
    logic clear8;

    always #5 clk = ~clk;

    cmp_window_stats_if #(.WIDTH(4), .CNT_W(4)) bus4 ();
    cmp_window_stats_if #(.WIDTH(4), .CNT_W(4)) bus8 ();

    cmp_window_stats #(.WIDTH(4), .WINDOW(4), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear4),
        .bus   (bus4.slave)
    );

    cmp_window_stats #(.WIDTH(4), .WINDOW(8), .CNT_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear8),
        .bus   (bus8.slave)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] f;
    } smp_t;

    typedef struct packed {
        logic       ov;
        logic       ir;
        logic [3:0] eq;
        logic [3:0] gt;
        logic [3:0] lt;
        logic [3:0] mx;
        logic [3:0] mn;
        logic       fe;
    } obs_t;

    smp_t q4[$];
    smp_t q8[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // What an ideal comparator would report: {eq, gt, lt}
    function automatic logic [2:0] truth(input logic [3:0] x, input logic [3:0] y);
        return {x == y, x > y, x < y};
    endfunction

    function automatic obs_t get(input int sel);
        obs_t o;
        if (sel == 4) begin
            o = {bus4.out_valid, bus4.in_ready, bus4.eq_cnt, bus4.gt_cnt,
                 bus4.lt_cnt, bus4.max_val, bus4.min_val, bus4.flag_err};
        end else begin
            o = {bus8.out_valid, bus8.in_ready, bus8.eq_cnt, bus8.gt_cnt,
                 bus8.lt_cnt, bus8.max_val, bus8.min_val, bus8.flag_err};
        end
        return o;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [3:0] aa,
                          input logic [3:0] bb, input logic [2:0] f);
        if (sel == 4) begin
            bus4.in_valid = v; bus4.a = aa; bus4.b = bb;
            {bus4.aeqb, bus4.agtb, bus4.altb} = f;
        end else begin
            bus8.in_valid = v; bus8.a = aa; bus8.b = bb;
            {bus8.aeqb, bus8.agtb, bus8.altb} = f;
        end
    endtask

    task automatic set_ordy(input int sel, input logic v);
        if (sel == 4) bus4.out_ready = v;
        else          bus8.out_ready = v;
    endtask

    // Present one sample for one cycle; the block must be in ACC
    task automatic send(input int sel, input logic [3:0] aa, input logic [3:0] bb,
                        input logic [2:0] f);
        obs_t o;
        smp_t s;
        o = get(sel);
        chk($sformatf("in_ready_before_accept_w%0d", sel), 16'(o.ir), 16'd1);
        chk($sformatf("out_valid_before_accept_w%0d", sel), 16'(o.ov), 16'd0);
        set_in(sel, 1'b1, aa, bb, f);
        step();
        set_in(sel, 1'b0, 4'd0, 4'd0, 3'd0);
        s.a = aa; s.b = bb; s.f = f;
        if (sel == 4) q4.push_back(s);
        else          q8.push_back(s);
        $display("w%0d accept a=%0d b=%0d flags=%b", sel, aa, bb, f);
    endtask

    // Expected record from the samples accepted in the current window
    task automatic check_rec(input int sel, input string tag);
        smp_t w[$];
        obs_t o;
        int   eq = 0, gt = 0, lt = 0, mx = 0, mn = 15, fe = 0;
        if (sel == 4) w = q4;
        else          w = q8;
        foreach (w[i]) begin
            if (w[i].f == truth(w[i].a, w[i].b)) begin
                if (w[i].a == w[i].b)     eq++;
                else if (w[i].a > w[i].b) gt++;
                else                      lt++;
            end else begin
                fe = 1;
            end
            if (int'(w[i].a) > mx) mx = int'(w[i].a);
            if (int'(w[i].b) > mx) mx = int'(w[i].b);
            if (int'(w[i].a) < mn) mn = int'(w[i].a);
            if (int'(w[i].b) < mn) mn = int'(w[i].b);
        end
        o = get(sel);
        chk({tag, "_out_valid"}, 16'(o.ov), 16'd1);
        chk({tag, "_in_ready"},  16'(o.ir), 16'd0);
        chk({tag, "_eq_cnt"},    16'(o.eq), 16'(eq));
        chk({tag, "_gt_cnt"},    16'(o.gt), 16'(gt));
        chk({tag, "_lt_cnt"},    16'(o.lt), 16'(lt));
        chk({tag, "_max_val"},   16'(o.mx), 16'(mx));
        chk({tag, "_min_val"},   16'(o.mn), 16'(mn));
        chk({tag, "_flag_err"},  16'(o.fe), 16'(fe));
        chk({tag, "_count_sum"}, 16'(o.eq) + 16'(o.gt) + 16'(o.lt), 16'(eq + gt + lt));
        $display("w%0d record %s eq=%0d gt=%0d lt=%0d max=%0d min=%0d err=%0d",
                 sel, tag, o.eq, o.gt, o.lt, o.mx, o.mn, o.fe);
    endtask

    task automatic check_empty(input int sel, input string tag);
        obs_t o;
        o = get(sel);
        chk({tag, "_out_valid"}, 16'(o.ov), 16'd0);
        chk({tag, "_in_ready"},  16'(o.ir), 16'd1);
        chk({tag, "_counts"},    16'({o.eq, o.gt, o.lt}), 16'd0);
        chk({tag, "_max_val"},   16'(o.mx), 16'd0);
        chk({tag, "_min_val"},   16'(o.mn), 16'hF);
        chk({tag, "_flag_err"},  16'(o.fe), 16'd0);
    endtask

    // Check the held record, take it, and confirm an empty window follows
    task automatic pop(input int sel, input string tag);
        check_rec(sel, tag);
        set_ordy(sel, 1'b1);
        step();
        set_ordy(sel, 1'b0);
        if (sel == 4) q4.delete();
        else          q8.delete();
        check_empty(sel, {tag, "_after_pop"});
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic [2:0] rf;

        rst_n = 1'b0; clear4 = 1'b0; clear8 = 1'b0;
        set_in(4, 1'b0, 4'd0, 4'd0, 3'd0);
        set_in(8, 1'b0, 4'd0, 4'd0, 3'd0);
        set_ordy(4, 1'b0);
        set_ordy(8, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        check_empty(4, "reset_w4");
        check_empty(8, "reset_w8");

        // Asynchronous reset mid-window, asserted between clock edges
        send(4, 4'd12, 4'd2, truth(4'd12, 4'd2));
        send(4, 4'd0, 4'd7, truth(4'd0, 4'd7));
        #3;
        rst_n = 1'b0;
        #1;
        check_empty(4, "async_reset");
        q4.delete();
        step();
        rst_n = 1'b1;

        // Directed window with correct flags
        send(4, 4'd3, 4'd3, truth(4'd3, 4'd3));
        send(4, 4'd9, 4'd2, truth(4'd9, 4'd2));
        send(4, 4'd1, 4'd7, truth(4'd1, 4'd7));
        send(4, 4'd5, 4'd5, truth(4'd5, 4'd5));
        pop(4, "directed");

        // Same window, second sample carries a non-one-hot flag triple
        send(4, 4'd3, 4'd3, truth(4'd3, 4'd3));
        send(4, 4'd9, 4'd2, 3'b011);
        send(4, 4'd1, 4'd7, truth(4'd1, 4'd7));
        send(4, 4'd5, 4'd5, truth(4'd5, 4'd5));
        pop(4, "bad_flags");

        // Backpressure in HOLD while new samples are offered
        send(4, 4'd8, 4'd4, truth(4'd8, 4'd4));
        send(4, 4'd2, 4'd2, truth(4'd2, 4'd2));
        send(4, 4'd6, 4'd14, truth(4'd6, 4'd14));
        send(4, 4'd10, 4'd1, truth(4'd10, 4'd1));
        for (int i = 0; i < 5; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            set_in(4, 1'b1, ra, rb, truth(ra, rb));
            step();
            check_rec(4, $sformatf("hold_stall%0d", i));
        end
        set_in(4, 1'b0, 4'd0, 4'd0, 3'd0);
        pop(4, "hold_release");
        send(4, 4'd15, 4'd0, truth(4'd15, 4'd0));
        send(4, 4'd4, 4'd4, truth(4'd4, 4'd4));
        send(4, 4'd3, 4'd9, truth(4'd3, 4'd9));
        send(4, 4'd7, 4'd7, truth(4'd7, 4'd7));
        pop(4, "after_hold");

        // Clear during the 3rd sample: it and the partial window are discarded
        send(4, 4'd13, 4'd1, truth(4'd13, 4'd1));
        send(4, 4'd0, 4'd0, truth(4'd0, 4'd0));
        set_in(4, 1'b1, 4'd15, 4'd15, truth(4'd15, 4'd15));
        clear4 = 1'b1;
        step();
        clear4 = 1'b0;
        set_in(4, 1'b0, 4'd0, 4'd0, 3'd0);
        q4.delete();
        check_empty(4, "clear_mid");
        send(4, 4'd6, 4'd5, truth(4'd6, 4'd5));
        send(4, 4'd2, 4'd11, truth(4'd2, 4'd11));
        send(4, 4'd9, 4'd9, truth(4'd9, 4'd9));
        send(4, 4'd4, 4'd3, truth(4'd4, 4'd3));
        pop(4, "after_clear");

        // Clear in HOLD wins over a simultaneous out_ready
        send(4, 4'd1, 4'd2, truth(4'd1, 4'd2));
        send(4, 4'd3, 4'd4, truth(4'd3, 4'd4));
        send(4, 4'd5, 4'd6, truth(4'd5, 4'd6));
        send(4, 4'd7, 4'd8, 3'b000);
        set_ordy(4, 1'b1);
        clear4 = 1'b1;
        step();
        clear4 = 1'b0;
        set_ordy(4, 1'b0);
        q4.delete();
        check_empty(4, "clear_in_hold");

        // Random traffic with correct flags, idle gaps and random drain delay
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            send(8, ra, rb, truth(ra, rb));
            if (q8.size() == 8) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    step();
                    check_rec(8, $sformatf("rand_stall_s%0d", i));
                end
                pop(8, $sformatf("rand_s%0d", i));
            end
        end

        // One window with an all-zero flag triple on the 4th sample
        for (int i = 0; i < 8; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rf = (i == 3) ? 3'b000 : truth(ra, rb);
            send(8, ra, rb, rf);
        end
        chk("zero_flags_sum", 16'(bus8.eq_cnt) + 16'(bus8.gt_cnt) + 16'(bus8.lt_cnt), 16'd7);
        chk("zero_flags_err", 16'(bus8.flag_err), 16'd1);
        pop(8, "zero_flags");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/cmp_window_stats.md
Name: cmp_window_stats

Overview:
- Downstream consumer of the 4-bit magnitude comparator (outputs AeqB/AgtB/AltB).
- Accepts a stream of operand pairs together with the comparator's flags, and accumulates per-window statistics: eq/gt/lt counts, running max and running min over all operands.
- Cross-checks each flag triple against its own internal compare.
- Presents a result record with a valid/ready handshake at the end of each window of WINDOW accepted samples.

Parameters:
- WIDTH, 4, operand width (matches comparator A/B).
- WINDOW, 8, samples per statistics window; legal range 1 .. 2**CNT_W-1.
- CNT_W, 4, width of each count output.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clear  input  1  synchronous abort: drop current window, restart.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample.
- a  input  WIDTH  comparator operand A.
- b  input  WIDTH  comparator operand B.
- aeqb  input  1  comparator flag A==B.
- agtb  input  1  comparator flag A>B.
- altb  input  1  comparator flag A<B.
- out_valid  output  1  result record valid.
- out_ready  input  1  consumer takes record.
- eq_cnt  output  CNT_W  samples with A==B in window.
- gt_cnt  output  CNT_W  samples with A>B.
- lt_cnt  output  CNT_W  samples with A<B.
- max_val  output  WIDTH  largest of all a and b in window, unsigned.
- min_val  output  WIDTH  smallest of all a and b in window, unsigned.
- flag_err  output  1  at least one sample in window had flags disagreeing with the internal compare.

Behaviour:
- Reset (rst_n=0, async):
  - state=ACC; in_ready=1; out_valid=0; flag_err=0.
  - eq_cnt, gt_cnt, lt_cnt = 0; max_val=0; min_val={WIDTH{1'b1}}.
  - Sample counter=0.
- FSM states: ACC, HOLD.
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1; outputs frozen.
- Accept (ACC and in_valid=1):
  - Internal compare, unsigned: exp = {a==b, a>b, a<b}.
  - If {aeqb,agtb,altb} == exp: increment the matching count by 1.
  - Otherwise: no count changes, flag_err<=1 (sticky for the window). Covers non-one-hot, all-zero and wrong flags.
  - max_val <= max(max_val, a, b); min_val <= min(min_val, a, b). Always updated, even on a flag error.
  - Sample counter +1. A flag-error sample still counts toward the window.
- Window end: when the accepted sample is number WINDOW, go to HOLD on the next edge. Outputs then include that sample. Latency from the final accept to out_valid=1 is 1 cycle.
- HOLD:
  - in_valid is ignored and samples are not consumed.
  - On out_ready=1, the transfer happens at that edge. The next cycle is ACC with counts, counter and flag_err = 0, max_val=0, min_val=all-ones.
- out_valid never drops without out_ready, except on clear or reset.
- Bit widths: counts never wrap, because WINDOW < 2**CNT_W. max/min compares are unsigned, full WIDTH.
- clear=1: highest priority below reset, in any state.
  - Next cycle: ACC with reset values of counts, counter, flag_err, max_val and min_val.
  - A sample presented in the same cycle is discarded; in_ready is still 1 in ACC, so the upstream sees it as taken.
  - A record in HOLD is dropped even if out_ready=1 in the same cycle.
- WINDOW=1: every accept goes straight to HOLD. Throughput is 1 sample per 2 cycles at best.
- Reset mid-window or in HOLD: immediate return to reset values; no partial record is emitted.
- in_valid low in ACC: no state change.

Test Plan:
1. Reset with rst_n=0 mid-stream, asserted asynchronously between edges -> outputs go to reset values immediately (in_ready=1, out_valid=0, min_val=4'hF, max_val=0) without waiting for clk.
2. WINDOW=4, correct flags, pairs (3,3),(9,2),(1,7),(5,5) -> out_valid=1 one cycle after the 4th accept; eq_cnt=2, gt_cnt=1, lt_cnt=1, max_val=9, min_val=1, flag_err=0.
3. WINDOW=4, second sample (9,2) driven with flags 3'b011 -> gt_cnt=0, eq_cnt=2, lt_cnt=1, flag_err=1; max_val=9 still.
4. HOLD backpressure: keep out_ready=0 for 5 cycles while in_valid=1 with new data -> in_ready=0, record stable for all 5 cycles. Then set out_ready=1 -> next cycle ACC with counts 0, and the next sample is counted in the new window.
5. clear asserted during the 3rd sample of a window -> that sample is discarded. The following 4 samples form a complete window whose counts reflect only those 4 samples.
6. Random 200 samples with correct flags, WINDOW=8 -> every record matches the scoreboard, eq+gt+lt=8, flag_err=0. Then one window with the all-zero flag triple injected -> flag_err=1 and eq+gt+lt=7.
